// File: rtl/queue_consumer_pkg.sv
// Shared constants, FSM state encoding and the request record for the
// TX queue consumer.
package queue_consumer_pkg;

   localparam int NB_QUEUES        = 4;
   localparam int QUEUE_ADDR_WIDTH = $clog2(NB_QUEUES);
   localparam int MAX_BURST        = 8;
   localparam int SIZE_WIDTH       = $clog2(MAX_BURST) + 1;
   localparam int FLIT_BYTES       = 64;
   // Ring offsets are RB_AWIDTH bits; rb_size itself needs one extra bit.
   localparam int RB_AWIDTH        = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [QUEUE_ADDR_WIDTH-1:0] queue_id;
      logic [63:0]                 addr;
      logic [SIZE_WIDTH-1:0]       size;
   } tx_req_t;

endpackage

// File: rtl/queue_consumer_if.sv
// Configuration, doorbell, DMA request and head write-back signals.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// the producer holds its payload stable while valid && !ready and never
// withdraws valid before the transfer.
interface queue_consumer_if;
   import queue_consumer_pkg::*;

   logic [RB_AWIDTH:0]            rb_size;
   logic [QUEUE_ADDR_WIDTH-1:0]   cfg_queue_id;
   logic [63:0]                   cfg_kmem_addr;
   logic                          cfg_wr_en;
   logic [QUEUE_ADDR_WIDTH-1:0]   in_queue_id;
   logic [RB_AWIDTH-1:0]          in_tail;
   logic                          in_valid;
   logic                          in_ready;
   logic [QUEUE_ADDR_WIDTH-1:0]   out_queue_id;
   logic [63:0]                   out_addr;
   logic [SIZE_WIDTH-1:0]         out_size;
   logic                          out_valid;
   logic                          out_ready;
   logic [QUEUE_ADDR_WIDTH-1:0]   head_wr_queue;
   logic [RB_AWIDTH-1:0]          head_wr_data;
   logic                          head_wr_en;
   logic [31:0]                   bad_doorbell_cnt;

   modport master (
      output rb_size, cfg_queue_id, cfg_kmem_addr, cfg_wr_en,
      output in_queue_id, in_tail, in_valid, out_ready,
      input  in_ready, out_queue_id, out_addr, out_size, out_valid,
      input  head_wr_queue, head_wr_data, head_wr_en, bad_doorbell_cnt
   );

   modport slave (
      input  rb_size, cfg_queue_id, cfg_kmem_addr, cfg_wr_en,
      input  in_queue_id, in_tail, in_valid, out_ready,
      output in_ready, out_queue_id, out_addr, out_size, out_valid,
      output head_wr_queue, head_wr_data, head_wr_en, bad_doorbell_cnt
   );

endinterface

// File: rtl/queue_consumer_rr_arbiter.sv
// Combinational round-robin pick: first set bit of pending at or after
// start, wrapping around. grant is one-hot, valid says anything was set.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         pending,
   input  logic [$clog2(N)-1:0] start,
   output logic [N-1:0]         grant,
   output logic                 valid
);
   localparam int PW = $clog2(N);

   logic [PW-1:0] idx;

   // Rotate the search origin to start and take the first pending queue.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(start) + i) % N);
         if (!valid && pending[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/queue_consumer.sv
// TX queue consumer: drains per-queue rings by round-robin, emitting
// non-wrapping DMA read requests of at most MAX_BURST flits and writing
// back the advanced head after each accepted request.
module queue_consumer
   import queue_consumer_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   queue_consumer_if.slave bus,
   output state_t          dbg_state
);
   localparam int QW = QUEUE_ADDR_WIDTH;

   logic [RB_AWIDTH-1:0] head_q [NB_QUEUES];
   logic [RB_AWIDTH-1:0] tail_q [NB_QUEUES];
   logic [RB_AWIDTH-1:0] head_n [NB_QUEUES];
   logic [RB_AWIDTH-1:0] tail_n [NB_QUEUES];
   logic [63:0]          kmem_q [NB_QUEUES];
   logic [NB_QUEUES-1:0] pending_q;

   state_t               state_q;
   logic [QW-1:0]        rr_ptr_q;
   logic [QW-1:0]        sel_q;
   tx_req_t              req_q;
   logic                 out_valid_q;
   logic                 head_wr_en_q;
   logic [QW-1:0]        head_wr_queue_q;
   logic [RB_AWIDTH-1:0] head_wr_data_q;
   logic [31:0]          bad_cnt_q;

   logic [NB_QUEUES-1:0] grant;
   logic                 arb_valid;
   logic [QW-1:0]        grant_idx;
   logic [QW-1:0]        rr_next;
   logic [RB_AWIDTH-1:0] rb_mask;
   logic                 db_fire;
   logic                 db_good;
   logic                 handshake;
   logic [RB_AWIDTH-1:0] new_head;
   logic [RB_AWIDTH-1:0] occ;
   logic [RB_AWIDTH:0]   to_end;
   logic [RB_AWIDTH:0]   burst_len;

   rr_arbiter #(.N(NB_QUEUES)) u_arb (
      .pending (pending_q),
      .start   (rr_ptr_q),
      .grant   (grant),
      .valid   (arb_valid)
   );

   assign rb_mask   = RB_AWIDTH'(bus.rb_size - 1'b1);
   assign db_fire   = bus.in_valid && bus.in_ready;
   assign db_good   = db_fire && ({1'b0, bus.in_tail} < bus.rb_size);
   assign handshake = (state_q == ST_EMIT) && bus.out_ready;
   assign new_head  = (head_q[sel_q] + RB_AWIDTH'(req_q.size)) & rb_mask;
   assign occ       = (tail_q[sel_q] - head_q[sel_q]) & rb_mask;
   assign to_end    = bus.rb_size - {1'b0, head_q[sel_q]};
   assign rr_next   = (sel_q == QW'(NB_QUEUES - 1)) ? '0 : sel_q + 1'b1;

   // One-hot grant to queue index.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NB_QUEUES; i++) begin
         if (grant[i]) grant_idx = QW'(i);
      end
   end

   // Burst size: occupancy, clipped at the ring end and at MAX_BURST.
   always_comb begin
      burst_len = {1'b0, occ};
      if (to_end < burst_len) burst_len = to_end;
      if ((RB_AWIDTH+1)'(MAX_BURST) < burst_len) burst_len = (RB_AWIDTH+1)'(MAX_BURST);
   end

   // Next head/tail per queue; configuration overrides doorbell and drain.
   always_comb begin
      for (int i = 0; i < NB_QUEUES; i++) begin
         head_n[i] = head_q[i];
         tail_n[i] = tail_q[i];
         if (handshake && sel_q == QW'(i)) head_n[i] = new_head;
         if (db_good && bus.in_queue_id == QW'(i)) tail_n[i] = bus.in_tail;
         if (bus.cfg_wr_en && bus.cfg_queue_id == QW'(i)) begin
            head_n[i] = '0;
            tail_n[i] = '0;
         end
      end
   end

   // Ring base addresses are plain storage written by configuration.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB_QUEUES; i++) begin
         if (bus.cfg_wr_en && bus.cfg_queue_id == QW'(i)) kmem_q[i] <= bus.cfg_kmem_addr;
      end
   end

   // Queue state, bad-doorbell counter and the IDLE/CALC/EMIT request FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NB_QUEUES; i++) begin
            head_q[i] <= '0;
            tail_q[i] <= '0;
         end
         pending_q       <= '0;
         state_q         <= ST_IDLE;
         rr_ptr_q        <= '0;
         sel_q           <= '0;
         req_q           <= '0;
         out_valid_q     <= 1'b0;
         head_wr_en_q    <= 1'b0;
         head_wr_queue_q <= '0;
         head_wr_data_q  <= '0;
         bad_cnt_q       <= '0;
      end else begin
         for (int i = 0; i < NB_QUEUES; i++) begin
            head_q[i]    <= head_n[i];
            tail_q[i]    <= tail_n[i];
            pending_q[i] <= (head_n[i] != tail_n[i]);
         end
         if (db_fire && !db_good && bad_cnt_q != '1) bad_cnt_q <= bad_cnt_q + 1'b1;
         head_wr_en_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  sel_q   <= grant_idx;
                  state_q <= ST_CALC;
               end
            end
            ST_CALC: begin
               // A doorbell may have emptied the queue since selection.
               if (occ != '0) begin
                  req_q.queue_id <= sel_q;
                  req_q.addr     <= kmem_q[sel_q] + (64'(head_q[sel_q]) * 64'(FLIT_BYTES));
                  req_q.size     <= SIZE_WIDTH'(burst_len);
                  out_valid_q    <= 1'b1;
                  state_q        <= ST_EMIT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_EMIT: begin
               if (bus.out_ready) begin
                  out_valid_q     <= 1'b0;
                  head_wr_en_q    <= 1'b1;
                  head_wr_queue_q <= sel_q;
                  head_wr_data_q  <= new_head;
                  rr_ptr_q        <= rr_next;
                  state_q         <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready         = !rst;
   assign bus.out_queue_id     = req_q.queue_id;
   assign bus.out_addr         = req_q.addr;
   assign bus.out_size         = req_q.size;
   assign bus.out_valid        = out_valid_q;
   assign bus.head_wr_queue    = head_wr_queue_q;
   assign bus.head_wr_data     = head_wr_data_q;
   assign bus.head_wr_en       = head_wr_en_q;
   assign bus.bad_doorbell_cnt = bad_cnt_q;
   assign dbg_state            = state_q;

endmodule

// File: tb/tb_queue_consumer.sv
// Bench for queue_consumer: directed scenarios plus random doorbell batches
// checked against a transaction-level ring model.
module tb_queue_consumer;
   import queue_consumer_pkg::*;

   localparam int QW    = QUEUE_ADDR_WIDTH;
   localparam int REQ_W = QW + 64 + SIZE_WIDTH;
   localparam int HW_W  = QW + RB_AWIDTH;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   rst;
   state_t dbg_state;

   queue_consumer_if bus();

   queue_consumer dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [REQ_W-1:0] exp_q[$];
   logic [HW_W-1:0]  exp_hq[$];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] m_kmem [NB_QUEUES];
   int          m_head [NB_QUEUES];
   int          m_tail [NB_QUEUES];
   int          m_rr;
   int          m_rb;
   longint      m_bad;

   task automatic m_doorbell(input int q, input int t);
      if (t >= m_rb) begin
         if (m_bad != 64'hffff_ffff) m_bad++;
      end else begin
         m_tail[q] = t;
      end
   endtask

   function automatic bit m_any();
      for (int q = 0; q < NB_QUEUES; q++) if (m_head[q] != m_tail[q]) return 1'b1;
      return 1'b0;
   endfunction

   // Next request: first non-empty ring from the round-robin pointer.
   task automatic m_issue(output logic [REQ_W-1:0] r);
      int q, occ, to_end, sz;
      logic [63:0] addr;
      q = 0;
      for (int k = NB_QUEUES - 1; k >= 0; k--) begin
         if (m_head[(m_rr + k) % NB_QUEUES] != m_tail[(m_rr + k) % NB_QUEUES]) q = (m_rr + k) % NB_QUEUES;
      end
      occ    = (m_tail[q] - m_head[q] + m_rb) % m_rb;
      to_end = m_rb - m_head[q];
      sz     = occ;
      if (to_end < sz) sz = to_end;
      if (MAX_BURST < sz) sz = MAX_BURST;
      addr      = m_kmem[q] + 64'(m_head[q]) * 64'(FLIT_BYTES);
      r         = {QW'(q), addr, SIZE_WIDTH'(sz)};
      exp_q.push_back(r);
      m_head[q] = (m_head[q] + sz) % m_rb;
      exp_hq.push_back({QW'(q), RB_AWIDTH'(m_head[q])});
      m_rr      = (q + 1) % NB_QUEUES;
   endtask

   task automatic m_reset();
      for (int q = 0; q < NB_QUEUES; q++) begin
         m_head[q] = 0;
         m_tail[q] = 0;
      end
      m_rr  = 0;
      m_bad = 0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check_eq("req_spurious", 128'(bus.out_valid), 128'(0));
            else check_eq("req", 128'({bus.out_queue_id, bus.out_addr, bus.out_size}), 128'(exp_q.pop_front()));
         end
         if (bus.head_wr_en) begin
            if (exp_hq.size() == 0) check_eq("head_wr_spurious", 128'(bus.head_wr_en), 128'(0));
            else check_eq("head_wr", 128'({bus.head_wr_queue, bus.head_wr_data}), 128'(exp_hq.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   int bx_q [4];
   int bx_t [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doorbell(input int q, input int t);
      bus.in_queue_id = QW'(q);
      bus.in_tail     = RB_AWIDTH'(t);
      bus.in_valid    = 1'b1;
      m_doorbell(q, t);
      tick();
      bus.in_valid    = 1'b0;
   endtask

   task automatic cfg_all();
      for (int q = 0; q < NB_QUEUES; q++) begin
         m_kmem[q]         = (64'd1 << 63) | (64'(q) << 32);
         m_head[q]         = 0;
         m_tail[q]         = 0;
         bus.cfg_queue_id  = QW'(q);
         bus.cfg_kmem_addr = m_kmem[q];
         bus.cfg_wr_en     = 1'b1;
         tick();
      end
      bus.cfg_wr_en = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_hq.size() != 0) && n < 2000) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end
      check_eq("drain_left", 128'(exp_q.size() + exp_hq.size()), 128'(0));
      bus.out_ready = 1'b1;
      repeat (6) tick();
      check_eq("idle_out_valid", 128'(bus.out_valid), 128'(0));
   endtask

   task automatic wait_emit(output int w);
      w = 0;
      while (!bus.out_valid && w < 10) begin
         tick();
         w++;
      end
      check_eq("emit_seen", 128'(bus.out_valid), 128'(1));
   endtask

   // First doorbell fixes the first request; extras either follow at once
   // (never to the first queue) or are issued while that request is stalled.
   task automatic run_batch(input int fq, input int ft, input int nx, input bit during_emit, input int hold);
      logic [REQ_W-1:0] first, tmp;
      int w;
      bus.out_ready = 1'b0;
      doorbell(fq, ft);
      m_issue(first);
      if (!during_emit) for (int i = 0; i < nx; i++) doorbell(bx_q[i], bx_t[i]);
      wait_emit(w);
      if (!during_emit && nx == 0) check_eq("latency", 128'(w), 128'(2));
      if (during_emit) begin
         for (int i = 0; i < nx; i++) begin
            doorbell(bx_q[i], bx_t[i]);
            check_eq("hold_req", 128'({bus.out_valid, bus.out_queue_id, bus.out_addr, bus.out_size}), 128'({1'b1, first}));
         end
      end
      for (int h = 0; h < hold; h++) begin
         check_eq("hold_req", 128'({bus.out_valid, bus.out_queue_id, bus.out_addr, bus.out_size}), 128'({1'b1, first}));
         tick();
      end
      while (m_any()) m_issue(tmp);
      drain();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int w, fq, ft, nx;
      bit de;
      rst               = 1'b1;
      bus.rb_size       = 9'd64;
      bus.cfg_queue_id  = '0;
      bus.cfg_kmem_addr = '0;
      bus.cfg_wr_en     = 1'b0;
      bus.in_queue_id   = '0;
      bus.in_tail       = '0;
      bus.in_valid      = 1'b0;
      bus.out_ready     = 1'b0;
      m_rb              = 64;
      m_reset();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_eq("rst_out_valid", 128'(bus.out_valid), 128'(0));
      check_eq("rst_head_wr_en", 128'(bus.head_wr_en), 128'(0));
      check_eq("rst_bad_cnt", 128'(bus.bad_doorbell_cnt), 128'(0));
      check_eq("in_ready", 128'(bus.in_ready), 128'(1));
      check_eq("rst_state", 128'(dbg_state), 128'(ST_IDLE));

      // 1: single queue, three bursts ending at tail 20
      cfg_all();
      run_batch(1, 20, 0, 1'b0, 0);

      // 2: wrap at ring end (head 60, tail 4)
      cfg_all();
      run_batch(0, 56, 0, 1'b0, 0);
      run_batch(0, 60, 0, 1'b0, 0);
      run_batch(0, 4, 0, 1'b0, 0);
      check_eq("t2_head", 128'(m_head[0]), 128'(4));

      // 3: two queues doorbelled back to back alternate
      cfg_all();
      bx_q[0] = 2; bx_t[0] = 16;
      run_batch(0, 16, 1, 1'b0, 2);

      // 4: out-of-range tail is rejected and leaves q3 untouched
      doorbell(3, 64);
      check_eq("bad_cnt", 128'(bus.bad_doorbell_cnt), 128'(m_bad));
      repeat (5) begin
         tick();
         check_eq("bad_no_req", 128'(bus.out_valid), 128'(0));
      end
      run_batch(3, 3, 0, 1'b0, 0);

      // 5: stalled request, same-queue doorbell during the stall
      cfg_all();
      bx_q[0] = 1; bx_t[0] = 12;
      run_batch(1, 8, 1, 1'b1, 10);

      // 6: reset during EMIT
      cfg_all();
      bx_q[0] = 1; bx_t[0] = 6;
      bx_q[1] = 2; bx_t[1] = 7;
      bx_q[2] = 3; bx_t[2] = 9;
      run_batch(0, 5, 3, 1'b0, 0);
      bus.out_ready = 1'b0;
      doorbell(2, 12);
      wait_emit(w);
      rst = 1'b1;
      tick();
      check_eq("rst_mid_out_valid", 128'(bus.out_valid), 128'(0));
      check_eq("rst_mid_head_wr", 128'(bus.head_wr_en), 128'(0));
      rst = 1'b0;
      exp_q.delete();
      exp_hq.delete();
      m_reset();
      tick();
      check_eq("rst_mid_bad_cnt", 128'(bus.bad_doorbell_cnt), 128'(0));
      check_eq("rst_mid_state", 128'(dbg_state), 128'(ST_IDLE));
      repeat (3) begin
         tick();
         check_eq("rst_mid_no_head_wr", 128'(bus.head_wr_en), 128'(0));
      end
      bx_q[0] = 1; bx_t[0] = 1;
      bx_q[1] = 2; bx_t[1] = 1;
      bx_q[2] = 3; bx_t[2] = 1;
      run_batch(0, 1, 3, 1'b0, 1);

      // random batches on a 32-flit ring
      m_rb        = 32;
      bus.rb_size = 9'd32;
      cfg_all();
      for (int b = 0; b < 25; b++) begin
         fq = int'($urandom_range(0, NB_QUEUES - 1));
         ft = (m_head[fq] + 1 + int'($urandom_range(0, m_rb - 2))) % m_rb;
         nx = int'($urandom_range(0, 3));
         de = 1'($urandom_range(0, 1));
         for (int i = 0; i < nx; i++) begin
            bx_q[i] = int'($urandom_range(0, NB_QUEUES - 1));
            if (!de && bx_q[i] == fq) bx_q[i] = (fq + 1) % NB_QUEUES;
            bx_t[i] = int'($urandom_range(0, m_rb + 8));
         end
         run_batch(fq, ft, nx, de, int'($urandom_range(0, 4)));
      end
      check_eq("rand_bad_cnt", 128'(bus.bad_doorbell_cnt), 128'(m_bad));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
